// File: rtl/game_controller_pkg.sv
// Shared constants for the card-matching game: default board geometry,
// controller state encodings and counter widths.
package game_controller_pkg;

    localparam int DEF_BITS_PER_BLOCK = 6;
    localparam int DEF_BLOCKS_WIDE    = 4;
    localparam int DEF_BLOCKS_HIGH    = 2;
    localparam int DEF_REVEAL_CYCLES  = 50000000;
    localparam int MOVES_W            = 8;

    localparam logic [1:0] S_PICK0  = 2'd0;
    localparam logic [1:0] S_PICK1  = 2'd1;
    localparam logic [1:0] S_REVEAL = 2'd2;
    localparam logic [1:0] S_WIN    = 2'd3;

endpackage

// File: rtl/game_cursor.sv
// Cursor register for the card grid: one direction per cycle with priority
// left > right > up > down, wrapping within the current row or column.
module game_cursor
    import game_controller_pkg::*;
#(
    parameter int BLOCKS_WIDE = DEF_BLOCKS_WIDE,
    parameter int BLOCKS_HIGH = DEF_BLOCKS_HIGH,
    parameter int CW          = BLOCKS_WIDE + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          move_en,
    input  logic          left,
    input  logic          right,
    input  logic          up,
    input  logic          down,
    output logic [CW-1:0] cursor
);

    localparam logic [CW-1:0] LAST_COL = CW'(BLOCKS_WIDE - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'((BLOCKS_HIGH - 1) * BLOCKS_WIDE);

    logic [CW-1:0] col;
    logic [CW-1:0] row_base;
    logic [CW-1:0] next_cursor;

    // Next position; row_base is the linear index of column 0 in this row.
    always_comb begin
        col         = cursor % CW'(BLOCKS_WIDE);
        row_base    = cursor - col;
        next_cursor = cursor;
        if (left) begin
            next_cursor = (col == {CW{1'b0}}) ? cursor + LAST_COL : cursor - CW'(1'b1);
        end else if (right) begin
            next_cursor = (col == LAST_COL) ? row_base : cursor + CW'(1'b1);
        end else if (up) begin
            next_cursor = (row_base == {CW{1'b0}}) ? cursor + LAST_ROW : cursor - CW'(BLOCKS_WIDE);
        end else if (down) begin
            next_cursor = (row_base == LAST_ROW) ? col : cursor + CW'(BLOCKS_WIDE);
        end else begin
            next_cursor = cursor;
        end
    end

    // Cursor register; clear wins over movement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor <= {CW{1'b0}};
        end else if (clear) begin
            cursor <= {CW{1'b0}};
        end else if (move_en) begin
            cursor <= next_cursor;
        end else begin
            cursor <= cursor;
        end
    end

endmodule

// File: rtl/game_controller.sv
// Matching-game sequencer: two card picks, timed reveal, symbol compare,
// match bookkeeping and win detection.
module game_controller
    import game_controller_pkg::*;
#(
    parameter int BLOCKS_WIDE    = DEF_BLOCKS_WIDE,
    parameter int BLOCKS_HIGH    = DEF_BLOCKS_HIGH,
    parameter int BITS_PER_BLOCK = DEF_BITS_PER_BLOCK,
    parameter int REVEAL_CYCLES  = DEF_REVEAL_CYCLES,
    parameter int NUM_BLOCKS     = BLOCKS_WIDE * BLOCKS_HIGH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic                               btn_up,
    input  logic                               btn_down,
    input  logic                               btn_select,
    input  logic                               new_game,
    input  logic [BITS_PER_BLOCK*NUM_BLOCKS-1:0] board,
    output logic [BLOCKS_WIDE:0]               cursor,
    output logic [NUM_BLOCKS-1:0]              selected,
    output logic [1:0]                         selectedCount,
    output logic [NUM_BLOCKS-1:0]              matched,
    output logic [MOVES_W-1:0]                 moves,
    output logic                               match_pulse,
    output logic                               miss_pulse,
    output logic                               win
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int TW    = $clog2(REVEAL_CYCLES);

    logic [1:0]                state;
    logic [IDX_W-1:0]          first_idx;
    logic [BITS_PER_BLOCK-1:0] sym_a;
    logic [BITS_PER_BLOCK-1:0] sym_b;
    logic [TW-1:0]             timer;
    logic [BITS_PER_BLOCK-1:0] syms [NUM_BLOCKS];
    logic [IDX_W-1:0]          cur_idx;
    logic [NUM_BLOCKS-1:0]     cur_onehot;
    logic [NUM_BLOCKS-1:0]     merged;
    logic                      restart;
    logic                      move_en;

    // Board unpacked into one symbol per card, plus per-cycle control decode.
    always_comb begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            syms[i] = board[i*BITS_PER_BLOCK +: BITS_PER_BLOCK];
        end
        cur_idx    = cursor[IDX_W-1:0];
        cur_onehot = NUM_BLOCKS'(1'b1) << cur_idx;
        merged     = matched | selected;
        restart    = new_game | ((state == S_WIN) & btn_select);
        move_en    = ((state == S_PICK0) | (state == S_PICK1)) & ~btn_select & ~restart;
    end

    game_cursor #(
        .BLOCKS_WIDE (BLOCKS_WIDE),
        .BLOCKS_HIGH (BLOCKS_HIGH),
        .CW          (BLOCKS_WIDE + 1)
    ) u_cursor (
        .clk     (clk),
        .rst     (rst),
        .clear   (restart),
        .move_en (move_en),
        .left    (btn_left),
        .right   (btn_right),
        .up      (btn_up),
        .down    (btn_down),
        .cursor  (cursor)
    );

    // Game FSM, reveal timer and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_PICK0;
            first_idx     <= {IDX_W{1'b0}};
            sym_a         <= {BITS_PER_BLOCK{1'b0}};
            sym_b         <= {BITS_PER_BLOCK{1'b0}};
            timer         <= {TW{1'b0}};
            selected      <= {NUM_BLOCKS{1'b0}};
            selectedCount <= 2'd0;
            matched       <= {NUM_BLOCKS{1'b0}};
            moves         <= {MOVES_W{1'b0}};
            match_pulse   <= 1'b0;
            miss_pulse    <= 1'b0;
            win           <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            if (restart) begin
                state         <= S_PICK0;
                timer         <= {TW{1'b0}};
                selected      <= {NUM_BLOCKS{1'b0}};
                selectedCount <= 2'd0;
                matched       <= {NUM_BLOCKS{1'b0}};
                moves         <= {MOVES_W{1'b0}};
                win           <= 1'b0;
            end else begin
                case (state)
                    S_PICK0: begin
                        if (btn_select && !matched[cur_idx]) begin
                            selected      <= cur_onehot;
                            selectedCount <= 2'd1;
                            first_idx     <= cur_idx;
                            state         <= S_PICK1;
                        end
                    end
                    S_PICK1: begin
                        if (btn_select && !matched[cur_idx] && (cur_idx != first_idx)) begin
                            selected      <= selected | cur_onehot;
                            selectedCount <= 2'd2;
                            sym_a         <= syms[first_idx];
                            sym_b         <= syms[cur_idx];
                            timer         <= TW'(REVEAL_CYCLES - 1);
                            if (moves != {MOVES_W{1'b1}}) begin
                                moves <= moves + MOVES_W'(1'b1);
                            end
                            state         <= S_REVEAL;
                        end
                    end
                    S_REVEAL: begin
                        if (timer == {TW{1'b0}}) begin
                            selected      <= {NUM_BLOCKS{1'b0}};
                            selectedCount <= 2'd0;
                            if (sym_a == sym_b) begin
                                matched     <= merged;
                                match_pulse <= 1'b1;
                                win         <= &merged;
                                state       <= (&merged) ? S_WIN : S_PICK0;
                            end else begin
                                miss_pulse <= 1'b1;
                                state      <= S_PICK0;
                            end
                        end else begin
                            timer <= timer - TW'(1'b1);
                        end
                    end
                    S_WIN: begin
                        state <= S_WIN;
                    end
                    default: begin
                        state <= S_PICK0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios with fixed expectations, then
// random button traffic against a row/column/pick-list model of the game.
module tb_game_controller;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = 8;
    localparam int B  = 6;
    localparam int RC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_left, btn_right, btn_up, btn_down, btn_select, new_game;
    logic [B*N-1:0] board;
    logic [W:0]   cursor;
    logic [N-1:0] selected, matched;
    logic [1:0]   selectedCount;
    logic [7:0]   moves;
    logic         match_pulse, miss_pulse, win;

    int checks   = 0;
    int failures = 0;

    // Game model: cursor as row/col, current turn as a list of picked cards.
    int       m_row, m_col, m_left, m_moves;
    int       m_picks[$];
    int       m_sym[N];
    bit [N-1:0] m_matched;
    bit       m_match_p, m_miss_p, m_won;

    always #5 clk = ~clk;

    game_controller #(
        .BLOCKS_WIDE(W), .BLOCKS_HIGH(H), .BITS_PER_BLOCK(B), .REVEAL_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .btn_select(btn_select), .new_game(new_game), .board(board),
        .cursor(cursor), .selected(selected), .selectedCount(selectedCount),
        .matched(matched), .moves(moves), .match_pulse(match_pulse),
        .miss_pulse(miss_pulse), .win(win)
    );

    function automatic void model_clear();
        m_row = 0; m_col = 0; m_left = 0; m_moves = 0;
        m_picks.delete();
        m_matched = '0; m_match_p = 1'b0; m_miss_p = 1'b0; m_won = 1'b0;
    endfunction

    function automatic void model_step(input bit l, r, u, d, s, ng);
        int idx;
        m_match_p = 1'b0;
        m_miss_p  = 1'b0;
        if (ng || (m_won && s)) begin
            model_clear();
        end else if (m_won) begin
            // frozen until restart
        end else if (m_picks.size() == 2) begin
            if (m_left == 0) begin
                if (m_sym[m_picks[0]] == m_sym[m_picks[1]]) begin
                    m_matched[m_picks[0]] = 1'b1;
                    m_matched[m_picks[1]] = 1'b1;
                    m_match_p = 1'b1;
                    m_won     = (m_matched == {N{1'b1}});
                end else begin
                    m_miss_p = 1'b1;
                end
                m_picks.delete();
            end else begin
                m_left--;
            end
        end else if (s) begin
            idx = m_row * W + m_col;
            if (!m_matched[idx] && !(m_picks.size() == 1 && m_picks[0] == idx)) begin
                m_picks.push_back(idx);
                if (m_picks.size() == 2) begin
                    m_left  = RC - 1;
                    m_moves = (m_moves < 255) ? m_moves + 1 : 255;
                end
            end
        end else if (l) m_col = (m_col + W - 1) % W;
        else if (r)     m_col = (m_col + 1) % W;
        else if (u)     m_row = (m_row + H - 1) % H;
        else if (d)     m_row = (m_row + 1) % H;
    endfunction

    function automatic logic [N-1:0] model_sel();
        logic [N-1:0] v = '0;
        foreach (m_picks[i]) v[m_picks[i]] = 1'b1;
        return v;
    endfunction

    task automatic load_board();
        for (int i = 0; i < N; i++) board[i*B +: B] = B'(m_sym[i]);
    endtask

    task automatic drive(input bit l, r, u, d, s, ng);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_select = s; new_game = ng;
        @(posedge clk);
        model_step(l, r, u, d, s, ng);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sel();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic goto(input int idx);
        for (int k = 0; k < W && m_col != idx % W; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < H && m_row != idx / W; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic pick_pair(input int a, input int b);
        goto(a); sel(); goto(b); sel();
        repeat (RC) idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {btn_left, btn_right, btn_up, btn_down, btn_select, new_game} = 6'b0;
        m_sym = '{1, 2, 3, 4, 1, 2, 3, 4};
        load_board();
        model_clear();
        repeat (2) @(negedge clk);
        checks++;
        if ({cursor, selected, selectedCount, matched, moves, match_pulse, miss_pulse, win} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs got cursor=%0d sel=%h cnt=%0d matched=%h moves=%0d pulses=%b%b win=%b expected all 0",
                     cursor, selected, selectedCount, matched, moves, match_pulse, miss_pulse, win);
        end
        rst = 1'b0;
    endtask

    task automatic test_move();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd3) begin failures++; $display("FAIL left_wrap cursor=%0d expected=3", cursor); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd7) begin failures++; $display("FAIL up_wrap cursor=%0d expected=7", cursor); end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd4) begin failures++; $display("FAIL right_wrap cursor=%0d expected=4", cursor); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd7) begin failures++; $display("FAIL dir_priority cursor=%0d expected=7", cursor); end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd4) begin failures++; $display("FAIL right_over_down cursor=%0d expected=4", cursor); end
    endtask

    task automatic test_match();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd0) begin failures++; $display("FAIL down_wrap cursor=%0d expected=0", cursor); end
        sel();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sel();
        checks++;
        if ({selected, selectedCount, moves} !== {8'h11, 2'd2, 8'd1}) begin
            failures++; $display("FAIL match_select sel=%h cnt=%0d moves=%0d expected 11/2/1", selected, selectedCount, moves);
        end
        for (int i = 0; i < RC - 1; i++) begin
            idle();
            checks++;
            if (selectedCount !== 2'd2 || match_pulse !== 1'b0) begin
                failures++; $display("FAIL reveal_hold cycle=%0d cnt=%0d pulse=%b expected 2/0", i, selectedCount, match_pulse);
            end
        end
        idle();
        checks++;
        if ({selected, selectedCount, matched, moves, match_pulse, miss_pulse} !== {8'h00, 2'd0, 8'h11, 8'd1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL match_result sel=%h cnt=%0d matched=%h moves=%0d pulses=%b%b expected 00/0/11/1/10",
                                 selected, selectedCount, matched, moves, match_pulse, miss_pulse);
        end
        idle();
        checks++; if (match_pulse !== 1'b0) begin failures++; $display("FAIL match_pulse_width got=%b expected=0", match_pulse); end
    endtask

    task automatic test_miss();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sel();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sel();
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd2) begin failures++; $display("FAIL reveal_no_move cursor=%0d expected=2", cursor); end
        idle();
        checks++;
        if (miss_pulse !== 1'b0) begin failures++; $display("FAIL miss_early got=%b expected=0", miss_pulse); end
        idle();
        checks++;
        if ({selected, matched, moves, match_pulse, miss_pulse} !== {8'h00, 8'h11, 8'd2, 1'b0, 1'b1}) begin
            failures++; $display("FAIL miss_result sel=%h matched=%h moves=%0d pulses=%b%b expected 00/11/2/01",
                                 selected, matched, moves, match_pulse, miss_pulse);
        end
    endtask

    task automatic test_ignored_selects();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sel();
        checks++;
        if ({cursor, selected, selectedCount} !== {5'd0, 8'h00, 2'd0}) begin
            failures++; $display("FAIL select_matched cursor=%0d sel=%h cnt=%0d expected 0/00/0", cursor, selected, selectedCount);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sel();
        sel();
        checks++;
        if ({selected, selectedCount} !== {8'h04, 2'd1}) begin
            failures++; $display("FAIL select_same_twice sel=%h cnt=%0d expected 04/1", selected, selectedCount);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({cursor, selected, selectedCount, moves} !== {5'd3, 8'h0C, 2'd2, 8'd3}) begin
            failures++; $display("FAIL select_beats_move cursor=%0d sel=%h cnt=%0d moves=%0d expected 3/0C/2/3",
                                 cursor, selected, selectedCount, moves);
        end
        repeat (RC) idle();
    endtask

    task automatic test_win();
        pick_pair(1, 5);
        pick_pair(2, 6);
        checks++;
        if ({win, matched} !== {1'b0, 8'h77}) begin failures++; $display("FAIL pre_win win=%b matched=%h expected 0/77", win, matched); end
        pick_pair(3, 7);
        checks++;
        if ({win, matched, match_pulse, moves} !== {1'b1, 8'hFF, 1'b1, 8'd6}) begin
            failures++; $display("FAIL win_set win=%b matched=%h pulse=%b moves=%0d expected 1/FF/1/6", win, matched, match_pulse, moves);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (cursor !== 5'd7) begin failures++; $display("FAIL win_frozen cursor=%0d expected=7", cursor); end
        sel();
        checks++;
        if ({win, matched, moves, cursor, selected} !== {1'b0, 8'h00, 8'd0, 5'd0, 8'h00}) begin
            failures++; $display("FAIL win_restart win=%b matched=%h moves=%0d cursor=%0d sel=%h expected 0/00/0/0/00",
                                 win, matched, moves, cursor, selected);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sel();
        checks++;
        if ({cursor, selectedCount} !== {5'd1, 2'd1}) begin
            failures++; $display("FAIL after_restart cursor=%0d cnt=%0d expected 1/1", cursor, selectedCount);
        end
    endtask

    task automatic test_reset_in_reveal();
        goto(5);
        sel();
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({cursor, selected, selectedCount, matched, moves, match_pulse, miss_pulse, win} !== 35'd0) begin
            failures++; $display("FAIL reset_mid_reveal cursor=%0d sel=%h cnt=%0d matched=%h moves=%0d expected all 0",
                                 cursor, selected, selectedCount, matched, moves);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < RC + 2; i++) begin
            idle();
            checks++;
            if ({match_pulse, miss_pulse, selected} !== 10'd0) begin
                failures++; $display("FAIL no_pulse_after_reset cycle=%0d pulses=%b%b sel=%h expected 00/00", i, match_pulse, miss_pulse, selected);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < N; i++) m_sym[i] = ($urandom_range(0, 1) * 32) + $urandom_range(0, 1);
        load_board();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
            checks++;
            if ({cursor, selected, selectedCount, matched, moves, match_pulse, miss_pulse, win} !==
                {5'(m_row * W + m_col), model_sel(), 2'(m_picks.size()), m_matched, 8'(m_moves), m_match_p, m_miss_p, m_won}) begin
                failures++;
                $display("FAIL random cyc=%0d got cur=%0d sel=%h cnt=%0d mat=%h mv=%0d p=%b%b w=%b expected cur=%0d sel=%h cnt=%0d mat=%h mv=%0d p=%b%b w=%b",
                         c, cursor, selected, selectedCount, matched, moves, match_pulse, miss_pulse, win,
                         m_row * W + m_col, model_sel(), m_picks.size(), m_matched, m_moves, m_match_p, m_miss_p, m_won);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_match();
        test_miss();
        test_ignored_selects();
        test_win();
        test_reset_in_reveal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
